// File: rtl/zap_fetch_queue.sv
`default_nettype none
// ============================================================================
// zap_fetch_queue : FWFT instruction queue with a 2-bit branch predictor table
// Rev 1.0
// ============================================================================
module zap_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int BP_ENTRIES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear_from_writeback,
    input  logic                       i_data_stall,
    input  logic                       i_clear_from_alu,
    input  logic                       i_clear_from_decode,
    input  logic                       i_valid,
    input  logic [31:0]                i_instruction,
    input  logic                       i_instr_abort,
    input  logic [31:0]                i_pc_ff,
    input  logic                       i_cpsr_ff_t,
    output logic                       o_ready,
    output logic                       o_valid,
    input  logic                       i_ready_from_decode,
    output logic [31:0]                o_instruction,
    output logic                       o_instr_abort,
    output logic [31:0]                o_pc_ff,
    output logic [31:0]                o_pc_plus_8_ff,
    output logic [1:0]                 o_taken_ff,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic                       i_confirm_from_alu,
    input  logic [31:0]                i_pc_from_alu,
    input  logic [1:0]                 i_taken
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BP_ENTRIES);

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_state_t;

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          sleep;
    logic          alive;

    logic [31:0]   mem_instr [DEPTH];
    logic          mem_abort [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_pc8   [DEPTH];
    logic [1:0]    mem_taken [DEPTH];

    bp_state_t     bp_tab [BP_ENTRIES];

    logic          flush;
    logic          hold;
    logic          enq;
    logic          deq;
    logic          bp_we;
    logic [BW-1:0] bp_widx;
    logic [BW-1:0] bp_ridx;
    bp_state_t     bp_wval;
    bp_state_t     bp_rval;
    logic          unused_pc_bits;

    // Writeback flush overrides the stall; the ALU/decode flushes do not.
    assign flush = i_clear_from_writeback |
                   (~i_data_stall & (i_clear_from_alu | i_clear_from_decode));
    assign hold  = i_data_stall & ~i_clear_from_writeback;

    assign o_valid = (count != '0);
    // alive keeps o_ready low while reset is asserted without looking at i_reset_n.
    assign o_ready = alive && (count < CW'(DEPTH)) && !sleep;

    assign enq = i_valid && o_ready && !flush && !hold;
    assign deq = o_valid && i_ready_from_decode && !flush && !hold;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            sleep  <= 1'b0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                sleep  <= 1'b0;
            end else if (!hold) begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (enq && i_instr_abort) sleep <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem_instr[wr_ptr] <= i_instr_abort ? 32'd0 : i_instruction;
            mem_abort[wr_ptr] <= i_instr_abort;
            mem_pc[wr_ptr]    <= i_pc_ff;
            mem_pc8[wr_ptr]   <= i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
            mem_taken[wr_ptr] <= bp_rval;
        end
    end

    assign o_instruction  = o_valid ? mem_instr[rd_ptr] : 32'd0;
    assign o_instr_abort  = o_valid ? mem_abort[rd_ptr] : 1'b0;
    assign o_pc_ff        = o_valid ? mem_pc[rd_ptr]    : 32'd0;
    assign o_pc_plus_8_ff = o_valid ? mem_pc8[rd_ptr]   : 32'd0;
    assign o_taken_ff     = o_valid ? mem_taken[rd_ptr] : 2'd0;
    assign o_count        = count;

    assign bp_we   = !i_data_stall && (i_clear_from_alu || i_confirm_from_alu);
    assign bp_widx = i_pc_from_alu[BW:1];
    assign bp_ridx = i_pc_ff[BW:1];
    assign unused_pc_bits = ^{i_pc_from_alu[31:BW+1], i_pc_from_alu[0]};

    always_comb begin
        bp_wval = SNT;
        if (i_clear_from_alu) begin
            case (bp_state_t'(i_taken))
                SNT:     bp_wval = WNT;
                WNT:     bp_wval = WT;
                WT:      bp_wval = WNT;
                default: bp_wval = WT;
            endcase
        end else begin
            case (bp_state_t'(i_taken))
                WT, ST:  bp_wval = ST;
                default: bp_wval = SNT;
            endcase
        end
    end

    // Same-cycle write to the index being read forwards the new state.
    assign bp_rval = (bp_we && (bp_widx == bp_ridx)) ? bp_wval : bp_tab[bp_ridx];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                bp_tab[i] <= SNT;
            end
        end else if (bp_we) begin
            bp_tab[bp_widx] <= bp_wval;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zap_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_zap_fetch_queue : directed and random checks against a queue-based model
// Rev 1.0
// ============================================================================
module tb_zap_fetch_queue;

    localparam int DEPTH      = 4;
    localparam int BP_ENTRIES = 64;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_wb, stall, clear_alu, clear_dec;
    logic          valid_in, abort_in, thumb, rdy_dec, confirm;
    logic [31:0]   instr_in, pc_in, pc_alu;
    logic [1:0]    taken_in;
    logic          ready_o, valid_o, abort_o;
    logic [31:0]   instr_o, pc_o, pc8_o;
    logic [1:0]    taken_o;
    logic [CW-1:0] count_o;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic        ab;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  tk;
    } ent_t;

    ent_t        q[$];
    bit          m_sleep;
    bit          m_alive;
    logic [1:0]  m_bp [BP_ENTRIES];

    always #5 clk = ~clk;

    zap_fetch_queue #(.DEPTH(DEPTH), .BP_ENTRIES(BP_ENTRIES)) dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_clear_from_writeback(clear_wb),
        .i_data_stall          (stall),
        .i_clear_from_alu      (clear_alu),
        .i_clear_from_decode   (clear_dec),
        .i_valid               (valid_in),
        .i_instruction         (instr_in),
        .i_instr_abort         (abort_in),
        .i_pc_ff               (pc_in),
        .i_cpsr_ff_t           (thumb),
        .o_ready               (ready_o),
        .o_valid               (valid_o),
        .i_ready_from_decode   (rdy_dec),
        .o_instruction         (instr_o),
        .o_instr_abort         (abort_o),
        .o_pc_ff               (pc_o),
        .o_pc_plus_8_ff        (pc8_o),
        .o_taken_ff            (taken_o),
        .o_count               (count_o),
        .i_confirm_from_alu    (confirm),
        .i_pc_from_alu         (pc_alu),
        .i_taken               (taken_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] next_state(input bit mispredict, input logic [1:0] t);
        if (mispredict) return (t == 2'd0) ? 2'd1 : (t == 2'd1) ? 2'd2 : (t == 2'd2) ? 2'd1 : 2'd2;
        return (t >= 2'd2) ? 2'd3 : 2'd0;
    endfunction

    function automatic bit m_ready();
        return m_alive && (q.size() < DEPTH) && !m_sleep;
    endfunction

    task automatic model_reset();
        q.delete();
        m_sleep = 1'b0;
        m_alive = 1'b0;
        for (int i = 0; i < BP_ENTRIES; i++) m_bp[i] = 2'd0;
    endtask

    task automatic check_outputs();
        ent_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("ready", 32'(ready_o), 32'(m_ready()));
        chk("valid", 32'(valid_o), 32'(q.size() != 0));
        chk("count", 32'(count_o), 32'(q.size()));
        chk("instr", instr_o, h.ins);
        chk("abort", 32'(abort_o), 32'(h.ab));
        chk("pc", pc_o, h.pc);
        chk("pc8", pc8_o, h.pc8);
        chk("taken", 32'(taken_o), 32'(h.tk));
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         fl = clear_wb || (!stall && (clear_alu || clear_dec));
        bit         hd = stall && !clear_wb;
        bit         en = valid_in && m_ready() && !fl && !hd;
        bit         dq = (q.size() != 0) && rdy_dec && !fl && !hd;
        bit         we = !stall && (clear_alu || confirm);
        int         wi = int'((pc_alu >> 1) % BP_ENTRIES);
        int         ri = int'((pc_in >> 1) % BP_ENTRIES);
        logic [1:0] wv = next_state(clear_alu, taken_in);
        ent_t       e;
        e.ins = abort_in ? 32'd0 : instr_in;
        e.ab  = abort_in;
        e.pc  = pc_in;
        e.pc8 = pc_in + (thumb ? 32'd4 : 32'd8);
        e.tk  = (we && wi == ri) ? wv : m_bp[ri];
        if (fl) begin
            q.delete();
            m_sleep = 1'b0;
        end else if (!hd) begin
            if (dq) void'(q.pop_front());
            if (en) begin
                q.push_back(e);
                if (abort_in) m_sleep = 1'b1;
            end
        end
        if (we) m_bp[wi] = wv;
        m_alive = 1'b1;
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear_wb = 0; stall = 0; clear_alu = 0; clear_dec = 0;
        valid_in = 0; abort_in = 0; thumb = 0; rdy_dec = 0; confirm = 0;
        instr_in = 32'd0; pc_in = 32'd0; pc_alu = 32'd0; taken_in = 2'd0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd0);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_alive = 1'b1;
        chk("ready_after_release", 32'(ready_o), 32'd1);
    endtask

    initial begin
        set_idle();
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        release_reset();

        // Fill to DEPTH with decode not consuming.
        valid_in = 1;
        for (int k = 0; k < 4; k++) begin
            pc_in = 32'h100 + 32'(4 * k);
            instr_in = $urandom;
            cycle();
        end
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_ready", 32'(ready_o), 32'd0);
        chk("fill_pc", pc_o, 32'h100);
        chk("fill_pc8", pc8_o, 32'h108);

        // Dequeue while full with a word on offer: only the dequeue happens.
        pc_in = 32'h110; instr_in = 32'hA5A5_0110; rdy_dec = 1;
        cycle();
        chk("full_offer_count", 32'(count_o), 32'd3);
        rdy_dec = 0;
        cycle();
        chk("full_refill_count", 32'(count_o), 32'd4);
        rdy_dec = 1;
        for (int k = 0; k < 10; k++) begin
            pc_in = 32'h200 + 32'(4 * k);
            instr_in = $urandom;
            cycle();
        end
        valid_in = 0;
        for (int k = 0; k < 5; k++) cycle();
        chk("drain_count", 32'(count_o), 32'd0);

        // Abort entry puts the queue to sleep until a flush.
        set_idle();
        valid_in = 1; abort_in = 1; pc_in = 32'h300; instr_in = 32'hDEAD_BEEF;
        cycle();
        abort_in = 0; pc_in = 32'h304;
        cycle();
        cycle();
        chk("abort_count", 32'(count_o), 32'd1);
        chk("abort_instr", instr_o, 32'd0);
        chk("abort_flag", 32'(abort_o), 32'd1);
        chk("abort_ready", 32'(ready_o), 32'd0);
        valid_in = 0; clear_dec = 1;
        cycle();
        clear_dec = 0;
        chk("abort_flush_count", 32'(count_o), 32'd0);
        chk("abort_flush_ready", 32'(ready_o), 32'd1);

        // Stall outranks the ALU flush; writeback outranks the stall.
        valid_in = 1; pc_in = 32'h400;
        cycle();
        pc_in = 32'h404;
        cycle();
        stall = 1; clear_alu = 1; pc_alu = 32'h40; taken_in = 2'd0; rdy_dec = 1; pc_in = 32'h408;
        cycle();
        chk("stall_alu_count", 32'(count_o), 32'd2);
        clear_alu = 0; clear_wb = 1;
        cycle();
        chk("stall_wb_count", 32'(count_o), 32'd0);
        set_idle();
        valid_in = 1; pc_in = 32'h40;
        cycle();
        chk("stall_no_bp_write", 32'(taken_o), 32'd0);
        set_idle();
        clear_dec = 1;
        cycle();

        // Predictor at PC 0x40 (index 0x20): three confirms then a mispredict.
        set_idle();
        pc_alu = 32'h40; taken_in = 2'd0;
        for (int k = 0; k < 3; k++) begin
            confirm = 1; valid_in = 1; pc_in = 32'h40; rdy_dec = 0;
            cycle();
            confirm = 0; valid_in = 0; rdy_dec = 1;
            chk("bp_confirm", 32'(taken_o), 32'd0);
            cycle();
        end
        clear_alu = 1; valid_in = 1; pc_in = 32'h40; rdy_dec = 0;
        cycle();
        clear_alu = 0;
        cycle();
        chk("bp_mispredict", 32'(taken_o), 32'd1);
        confirm = 1; taken_in = 2'd2; rdy_dec = 1;
        cycle();
        confirm = 0; valid_in = 0; rdy_dec = 0;
        chk("bp_bypass", 32'(taken_o), 32'd3);
        clear_dec = 1;
        cycle();

        // Thumb PC+4 wraps modulo 2^32.
        set_idle();
        valid_in = 1; thumb = 1; pc_in = 32'hFFFF_FFFE;
        cycle();
        valid_in = 0;
        chk("thumb_wrap_pc8", pc8_o, 32'h0000_0002);
        clear_dec = 1;
        cycle();

        // Randomised traffic with index collisions between read and write.
        for (int k = 0; k < 400; k++) begin
            clear_wb  = ($urandom_range(0, 99) < 3);
            stall     = ($urandom_range(0, 99) < 10);
            clear_alu = ($urandom_range(0, 99) < 4);
            clear_dec = ($urandom_range(0, 99) < 4);
            confirm   = ($urandom_range(0, 99) < 15);
            valid_in  = ($urandom_range(0, 99) < 70);
            abort_in  = ($urandom_range(0, 99) < 5);
            rdy_dec   = ($urandom_range(0, 99) < 50);
            thumb     = 1'($urandom);
            instr_in  = $urandom;
            pc_in     = 32'($urandom_range(0, 15)) << 2;
            pc_alu    = 32'($urandom_range(0, 15)) << 2;
            taken_in  = 2'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a fill.
        set_idle();
        clear_dec = 1;
        cycle();
        clear_dec = 0; valid_in = 1; pc_in = 32'h500;
        cycle();
        pc_in = 32'h504;
        cycle();
        chk("prefill_count", 32'(count_o), 32'd2);
        #3 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        set_idle();
        release_reset();
        valid_in = 1; pc_in = 32'h600;
        cycle();
        valid_in = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
